// File: rtl/gfx_span_rasterizer.sv
// Span rasterizer: clips a rectangle, walks it in LANES-wide beats row by
// row, optionally maps each pixel into a texture window (clamp or repeat),
// and limits unacknowledged beats with a credit counter.

// Maps a raw texel offset into a window [s0, s1).
module gfx_span_tex_map #(
  parameter int W = 16
) (
  input  logic         en,
  input  logic         mode,
  input  logic [W-1:0] raw,
  input  logic [W-1:0] s0,
  input  logic [W-1:0] s1,
  output logic [W-1:0] c
);
  logic [W-1:0] sum, lim, wmask;

  assign sum   = s0 + raw;
  assign lim   = s1 - W'(1);
  assign wmask = s1 - s0 - W'(1);

  // Clamp saturates at the last texel; repeat wraps inside a power-of-two window.
  always_comb begin
    c = '0;
    if (en) c = mode ? (s0 + (raw & wmask)) : ((sum < lim) ? sum : lim);
  end
endmodule

// One output lane: coverage bit and texture u for pixel x+IDX.
module gfx_span_lane #(
  parameter int W   = 16,
  parameter int IDX = 0
) (
  input  logic signed [W:0] x,
  input  logic signed [W:0] x1c,
  input  logic [W-1:0]      p0_x,
  input  logic [W-1:0]      s0,
  input  logic [W-1:0]      s1,
  input  logic              en,
  input  logic              mode,
  output logic              m,
  output logic [W-1:0]      u
);
  logic signed [W+1:0] xi;
  logic [W-1:0]        raw;

  // Extra bit keeps x+IDX from wrapping before the bound compare.
  assign xi  = $signed({x[W], x}) + $signed((W+2)'(IDX));
  assign m   = xi < $signed({x1c[W], x1c});
  // u offset is taken from the unclipped corner so clipping does not shift the texture.
  assign raw = x[W-1:0] + W'(IDX) - p0_x;

  gfx_span_tex_map #(.W(W)) u_map (.en, .mode, .raw, .s0, .s1, .c(u));
endmodule

module gfx_span_rasterizer #(
  parameter int POINT_WIDTH  = 16,
  parameter int LANES        = 4,
  parameter int CREDIT_DEPTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  output logic                         busy_o,
  output logic                         done_o,
  input  logic [POINT_WIDTH-1:0]       p0_x_i,
  input  logic [POINT_WIDTH-1:0]       p0_y_i,
  input  logic [POINT_WIDTH-1:0]       p1_x_i,
  input  logic [POINT_WIDTH-1:0]       p1_y_i,
  input  logic                         clip_en_i,
  input  logic [POINT_WIDTH-1:0]       clip0_x_i,
  input  logic [POINT_WIDTH-1:0]       clip0_y_i,
  input  logic [POINT_WIDTH-1:0]       clip1_x_i,
  input  logic [POINT_WIDTH-1:0]       clip1_y_i,
  input  logic                         tex_en_i,
  input  logic                         tex_mode_i,
  input  logic [POINT_WIDTH-1:0]       src0_x_i,
  input  logic [POINT_WIDTH-1:0]       src0_y_i,
  input  logic [POINT_WIDTH-1:0]       src1_x_i,
  input  logic [POINT_WIDTH-1:0]       src1_y_i,
  output logic                         pix_valid_o,
  input  logic                         pix_ready_i,
  output logic [POINT_WIDTH-1:0]       pix_x_o,
  output logic [POINT_WIDTH-1:0]       pix_y_o,
  output logic [LANES-1:0]             pix_mask_o,
  output logic [LANES*POINT_WIDTH-1:0] pix_u_o,
  output logic [POINT_WIDTH-1:0]       pix_v_o,
  input  logic                         ack_i
);
  localparam int W  = POINT_WIDTH;
  localparam int CW = $clog2(CREDIT_DEPTH + 1);
  localparam logic [CW-1:0] CRED = CW'(CREDIT_DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, SPAN, DRAIN} state_t;
  state_t state;

  logic [W-1:0]              p0x, p0y, p1x, p1y, c0x, c0y, c1x, c1y, s0x, s0y, s1x, s1y;
  logic                      clip_en, tex_en, tex_mode;
  logic signed [W:0]         x0c, x1c, y1c, cur_x, cur_y;
  logic signed [W:0]         lo_x, hi_x, lo_y, hi_y;
  logic [CW-1:0]             outst, outst_nx;
  logic                      accept, ack_eff, row_end, last_beat, empty, credit_ok;
  logic [LANES-1:0][W-1:0]   lane_u;
  logic [W-1:0]              raw_v;

  function automatic logic signed [W:0] sx(input logic [W-1:0] v);
    return $signed({v[W-1], v});
  endfunction
  function automatic logic signed [W:0] zx(input logic [W-1:0] v);
    return $signed({1'b0, v});
  endfunction
  function automatic logic signed [W:0] smax(input logic signed [W:0] a, input logic signed [W:0] b);
    return (a > b) ? a : b;
  endfunction
  function automatic logic signed [W:0] smin(input logic signed [W:0] a, input logic signed [W:0] b);
    return (a < b) ? a : b;
  endfunction

  // Clipped bounds in W+1 signed bits so unsigned clip values compare correctly.
  always_comb begin
    lo_x = clip_en ? smax(sx(p0x), zx(c0x)) : smax(sx(p0x), '0);
    lo_y = clip_en ? smax(sx(p0y), zx(c0y)) : smax(sx(p0y), '0);
    hi_x = clip_en ? smin(sx(p1x), zx(c1x)) : sx(p1x);
    hi_y = clip_en ? smin(sx(p1y), zx(c1y)) : sx(p1y);
  end

  assign empty     = (lo_x >= hi_x) || (lo_y >= hi_y);
  assign row_end   = ($signed({cur_x[W], cur_x}) + $signed((W+2)'(LANES))) >= $signed({x1c[W], x1c});
  assign last_beat = row_end && ((cur_y + $signed((W+1)'(1))) == y1c);
  assign accept    = pix_valid_o & pix_ready_i;
  assign ack_eff   = ack_i & (outst != '0);

  // Credit count: simultaneous accept and ack cancel; ack with nothing pending is dropped.
  always_comb begin
    outst_nx = outst;
    if (accept && !ack_eff)      outst_nx = outst + CW'(1);
    else if (!accept && ack_eff) outst_nx = outst - CW'(1);
  end
  assign credit_ok = outst_nx < CRED;

  assign pix_x_o = cur_x[W-1:0];
  assign pix_y_o = cur_y[W-1:0];
  assign pix_u_o = lane_u;
  assign raw_v   = cur_y[W-1:0] - p0y;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    gfx_span_lane #(.W(W), .IDX(i)) u_lane (
      .x(cur_x), .x1c(x1c), .p0_x(p0x), .s0(s0x), .s1(s1x),
      .en(tex_en), .mode(tex_mode), .m(pix_mask_o[i]), .u(lane_u[i])
    );
  end

  gfx_span_tex_map #(.W(W)) u_vmap (
    .en(tex_en), .mode(tex_mode), .raw(raw_v), .s0(s0y), .s1(s1y), .c(pix_v_o)
  );

  // Control FSM with operand capture, beat walk, credit gating and done pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      {p0x, p0y, p1x, p1y, c0x, c0y, c1x, c1y, s0x, s0y, s1x, s1y} <= '0;
      {clip_en, tex_en, tex_mode} <= '0;
      {x0c, x1c, y1c, cur_x, cur_y} <= '0;
      outst       <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      pix_valid_o <= 1'b0;
    end else begin
      outst  <= outst_nx;
      done_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          p0x <= p0_x_i;     p0y <= p0_y_i;     p1x <= p1_x_i;     p1y <= p1_y_i;
          c0x <= clip0_x_i;  c0y <= clip0_y_i;  c1x <= clip1_x_i;  c1y <= clip1_y_i;
          s0x <= src0_x_i;   s0y <= src0_y_i;   s1x <= src1_x_i;   s1y <= src1_y_i;
          clip_en  <= clip_en_i;
          tex_en   <= tex_en_i;
          tex_mode <= tex_mode_i;
          busy_o   <= 1'b1;
          state    <= SETUP;
        end
        SETUP: begin
          x0c   <= lo_x;
          x1c   <= hi_x;
          y1c   <= hi_y;
          cur_x <= lo_x;
          cur_y <= lo_y;
          if (empty) state <= DRAIN;
          else begin
            state       <= SPAN;
            pix_valid_o <= credit_ok;
          end
        end
        SPAN: begin
          if (accept && last_beat) begin
            state       <= DRAIN;
            pix_valid_o <= 1'b0;
          end else begin
            if (accept) begin
              cur_x <= row_end ? x0c : (cur_x + $signed((W+1)'(LANES)));
              if (row_end) cur_y <= cur_y + $signed((W+1)'(1));
            end
            pix_valid_o <= credit_ok;
          end
        end
        DRAIN: if (outst == '0) begin
          state  <= IDLE;
          done_o <= 1'b1;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
